aes_bram_read_responder: RTL and testbench

//  Target (responder) side of the AES word-read handshake: services aes_start_read/aes_bram_addr requests

---
 rtl/aes_bram_pkg.sv | 17 +
 rtl/aes_rd_latency_ctr.sv | 29 ++
 rtl/aes_bram_read_responder.sv | 100 ++++++++++
 tb/tb_aes_bram_read_responder.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/aes_bram_pkg.sv
// Shared types and constants for the AES BRAM read responder and its latency counter.
package aes_bram_pkg;

   localparam int AES_WORD_W      = 32;
   localparam int DEF_DEPTH_WORDS = 4096;
   localparam int DEF_BRAM_AW     = 12;
   localparam logic [AES_WORD_W-1:0] ERR_DATA = 32'h0000_0000;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ISSUE   = 3'd1,
      ST_WAIT    = 3'd2,
      ST_RESP    = 3'd3,
      ST_RELEASE = 3'd4
   } rd_state_t;

endpackage

// File: rtl/aes_rd_latency_ctr.sv
// Down-counter that marks the edge on which BRAM read data is valid.
// done is high while the count is zero; the owner samples data on that edge.
module aes_rd_latency_ctr #(
   parameter int RD_LATENCY = 2
) (
   input  logic aes_clk,
   input  logic aes_rst,
   input  logic load,
   input  logic dec,
   output logic done
);

   localparam int CW = 3;

   logic [CW-1:0] count_reg;

   always_ff @(posedge aes_clk or posedge aes_rst) begin
      if (aes_rst) begin
         count_reg <= '0;
      end else if (load) begin
         count_reg <= CW'(RD_LATENCY - 1);
      end else if (dec && (count_reg != '0)) begin
         count_reg <= count_reg - 1'b1;
      end
   end

   assign done = (count_reg == '0);

endmodule

// File: rtl/aes_bram_read_responder.sv
// Responder side of the AES word-read handshake: one BRAM read per accepted request,
// a one-cycle bram_complete pulse, and zeroed data with rd_error for bad addresses.
module aes_bram_read_responder
   import aes_bram_pkg::*;
#(
   parameter int RD_LATENCY  = 2,
   parameter int DEPTH_WORDS = DEF_DEPTH_WORDS,
   parameter int BRAM_AW     = DEF_BRAM_AW
) (
   input  logic                  aes_clk,
   input  logic                  aes_rst,
   input  logic                  aes_start_read,
   input  logic [31:0]           aes_bram_addr,
   output logic [AES_WORD_W-1:0] aes_bram_read_data,
   output logic                  bram_complete,
   output logic                  rd_error,
   output logic                  busy,
   output logic                  bram_en,
   output logic [BRAM_AW-1:0]    bram_addr,
   input  logic [AES_WORD_W-1:0] bram_dout,
   output logic [15:0]           rd_count
);

   localparam logic [29:0] DEPTH_LIM = 30'(DEPTH_WORDS);

   rd_state_t             state_reg, state_next;
   logic                  err_reg;
   logic [BRAM_AW-1:0]    bram_addr_reg;
   logic [AES_WORD_W-1:0] data_reg;
   logic [15:0]           rd_count_reg;
   logic                  lat_done;
   logic                  accept;
   logic                  req_err;

   assign accept  = (state_reg == ST_IDLE) && aes_start_read;
   assign req_err = (aes_bram_addr[1:0] != 2'b00) || (aes_bram_addr[31:2] >= DEPTH_LIM);

   aes_rd_latency_ctr #(
      .RD_LATENCY (RD_LATENCY)
   ) u_lat_ctr (
      .aes_clk (aes_clk),
      .aes_rst (aes_rst),
      .load    (state_reg == ST_ISSUE),
      .dec     (state_reg == ST_WAIT),
      .done    (lat_done)
   );

   always_ff @(posedge aes_clk or posedge aes_rst) begin
      if (aes_rst) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      unique case (state_reg)
         ST_IDLE:    if (aes_start_read) state_next = ST_ISSUE;
         ST_ISSUE:   state_next = ST_WAIT;
         ST_WAIT:    if (lat_done) state_next = ST_RESP;
         ST_RESP:    state_next = aes_start_read ? ST_RELEASE : ST_IDLE;
         ST_RELEASE: if (!aes_start_read) state_next = ST_IDLE;
         default:    state_next = ST_IDLE;
      endcase
   end

   // Outputs decode straight from the state register so an async reset clears them at once.
   always_comb begin
      bram_en       = (state_reg == ST_ISSUE) && !err_reg;
      bram_complete = (state_reg == ST_RESP);
      rd_error      = (state_reg == ST_RESP) && err_reg;
      busy          = (state_reg != ST_IDLE);
   end

   always_ff @(posedge aes_clk or posedge aes_rst) begin
      if (aes_rst) begin
         err_reg       <= 1'b0;
         bram_addr_reg <= '0;
         data_reg      <= '0;
         rd_count_reg  <= '0;
      end else begin
         if (accept) begin
            err_reg       <= req_err;
            bram_addr_reg <= aes_bram_addr[BRAM_AW+1:2];
         end
         if ((state_reg == ST_WAIT) && lat_done) begin
            data_reg <= err_reg ? ERR_DATA : bram_dout;
         end
         if (state_reg == ST_RESP) begin
            rd_count_reg <= rd_count_reg + 16'd1;
         end
      end
   end

   assign aes_bram_read_data = data_reg;
   assign bram_addr          = bram_addr_reg;
   assign rd_count           = rd_count_reg;

endmodule

// File: tb/tb_aes_bram_read_responder.sv
// Scoreboard bench: the driver queues expected responses from an address/memory model,
// a negedge monitor checks every bram_complete and bram_en the DUT presents.
module tb_aes_bram_read_responder;

   localparam int RD_LATENCY = 2;
   localparam int DEPTH      = 4096;
   localparam int AW         = 12;

   typedef struct {
      logic [31:0] data;
      logic        err;
   } exp_t;

   logic          aes_clk = 1'b0;
   logic          aes_rst = 1'b1;
   logic          aes_start_read = 1'b0;
   logic [31:0]   aes_bram_addr = '0;
   logic [31:0]   aes_bram_read_data;
   logic          bram_complete;
   logic          rd_error;
   logic          busy;
   logic          bram_en;
   logic [AW-1:0] bram_addr;
   logic [31:0]   bram_dout = '0;
   logic [15:0]   rd_count;

   logic [31:0]   mem [DEPTH];
   logic          v1 = 1'b0;
   logic [AW-1:0] a1 = '0;

   exp_t          exp_q[$];
   logic [AW-1:0] addr_q[$];
   int            n_cmp = 0;
   int            n_bad = 0;
   int            en_exp = 0;
   int            en_seen = 0;
   int            exp_cnt = 0;

   aes_bram_read_responder #(
      .RD_LATENCY  (RD_LATENCY),
      .DEPTH_WORDS (DEPTH),
      .BRAM_AW     (AW)
   ) dut (
      .aes_clk            (aes_clk),
      .aes_rst            (aes_rst),
      .aes_start_read     (aes_start_read),
      .aes_bram_addr      (aes_bram_addr),
      .aes_bram_read_data (aes_bram_read_data),
      .bram_complete      (bram_complete),
      .rd_error           (rd_error),
      .busy               (busy),
      .bram_en            (bram_en),
      .bram_addr          (bram_addr),
      .bram_dout          (bram_dout),
      .rd_count           (rd_count)
   );

   always #5 aes_clk = ~aes_clk;

   // Two-edge BRAM: enable sampled, then data driven one edge later; garbage otherwise.
   always @(posedge aes_clk) begin
      v1 <= bram_en;
      a1 <= bram_addr;
      if (v1) bram_dout <= mem[a1];
      else    bram_dout <= $urandom;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
      end
   endtask

   // Monitor: pops the scoreboard on every response and every BRAM enable.
   always @(negedge aes_clk) begin
      if (bram_en) begin
         en_seen++;
         if (addr_q.size() == 0) begin
            chk("unexpected_bram_en", 32'(bram_addr), 32'hFFFF_FFFF);
         end else begin
            chk("bram_addr", 32'(bram_addr), 32'(addr_q.pop_front()));
         end
      end
      if (!aes_rst && bram_complete) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_complete", 32'(bram_complete), 32'd0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("read_data", aes_bram_read_data, e.data);
            chk("rd_error", 32'(rd_error), 32'(e.err));
         end
      end
   end

   // Caller is positioned just after a negedge with the DUT idle.
   task automatic do_read(input logic [31:0] a, input int hold, input bit early_drop);
      exp_t e;
      int   lat;
      bit   got;
      e.err  = (a[1:0] != 2'b00) || (a[31:2] >= 30'(DEPTH));
      e.data = e.err ? 32'h0 : mem[a[13:2]];
      exp_q.push_back(e);
      if (!e.err) begin
         addr_q.push_back(a[13:2]);
         en_exp++;
      end
      aes_start_read = 1'b1;
      aes_bram_addr  = a;
      lat = 0;
      got = 1'b0;
      while (!got && lat < 20) begin
         @(negedge aes_clk);
         lat++;
         if (lat == 1) begin
            aes_bram_addr = $urandom;
            if (early_drop) aes_start_read = 1'b0;
         end
         if (bram_complete) got = 1'b1;
      end
      chk("complete_seen", 32'(got), 32'd1);
      if (got) chk("latency", 32'(lat), 32'(RD_LATENCY + 2));
      exp_cnt++;
      $display("read addr=0x%08h err=%0d exp=0x%08h got=0x%08h lat=%0d hold=%0d drop=%0d",
               a, e.err, e.data, aes_bram_read_data, lat, hold, early_drop);
      if (!early_drop) begin
         for (int i = 0; i < hold; i++) begin
            @(negedge aes_clk);
            chk("release_busy", 32'(busy), 32'd1);
            chk("release_data", aes_bram_read_data, e.data);
         end
      end
      aes_start_read = 1'b0;
      @(negedge aes_clk);
      chk("rd_count", 32'(rd_count), 32'(exp_cnt[15:0]));
      chk("idle_busy", 32'(busy), 32'd0);
      chk("held_data", aes_bram_read_data, e.data);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] a;
      int          w, r;
      for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
      mem[5] = 32'hCAFE_F00D;

      // Reset held with a pending request: everything stays zero.
      aes_start_read = 1'b1;
      aes_bram_addr  = 32'h14;
      for (int i = 0; i < 3; i++) begin
         @(negedge aes_clk);
         chk("rst_data", aes_bram_read_data, 32'h0);
         chk("rst_complete", 32'(bram_complete), 32'd0);
         chk("rst_busy", 32'(busy), 32'd0);
         chk("rst_bram_addr", 32'(bram_addr), 32'd0);
         chk("rst_count", 32'(rd_count), 32'd0);
         chk("rst_err", 32'(rd_error), 32'd0);
      end
      aes_rst = 1'b0;
      do_read(32'h14, 0, 1'b0);

      for (int i = 0; i < 12; i++) do_read(32'(i * 4), 0, 1'b0);

      do_read(32'h4002, 0, 1'b0);
      do_read(32'h4000, 0, 1'b0);

      do_read(32'h20, 10, 1'b0);
      do_read(32'h24, 0, 1'b0);

      for (int i = 0; i < 40; i++) begin
         r = $urandom_range(0, 9);
         if (r < 6) begin
            w = $urandom_range(0, DEPTH - 1);
            a = 32'(w) << 2;
         end else if (r == 6) begin
            w = $urandom_range(0, DEPTH - 1);
            a = (32'(w) << 2) | 32'($urandom_range(1, 3));
         end else if (r == 7) begin
            a = 32'($urandom_range(DEPTH, 32'h3FFF_FFFF)) << 2;
         end else if (r == 8) begin
            a = 32'(DEPTH - 1) << 2;
         end else begin
            a = 32'(DEPTH) << 2;
         end
         do_read(a, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      end

      // Asynchronous reset between edges while the read is waiting on the BRAM.
      aes_start_read = 1'b1;
      aes_bram_addr  = 32'h40;
      addr_q.push_back(12'd16);
      en_exp++;
      @(negedge aes_clk);
      @(negedge aes_clk);
      chk("pre_rst_busy", 32'(busy), 32'd1);
      #2 aes_rst = 1'b1;
      #1;
      chk("async_busy", 32'(busy), 32'd0);
      chk("async_bram_en", 32'(bram_en), 32'd0);
      chk("async_count", 32'(rd_count), 32'd0);
      chk("async_data", aes_bram_read_data, 32'h0);
      aes_start_read = 1'b0;
      exp_cnt = 0;
      repeat (3) @(negedge aes_clk);
      aes_rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge aes_clk);
         chk("post_rst_complete", 32'(bram_complete), 32'd0);
         chk("post_rst_data", aes_bram_read_data, 32'h0);
      end

      chk("bram_en_total", 32'(en_seen), 32'(en_exp));
      chk("resp_left", 32'(exp_q.size()), 32'd0);
      chk("en_left", 32'(addr_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
